// File: rtl/pll_sup_pkg.sv
// Shared types and 27 MHz default timing for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } pll_sup_state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 27000;
  localparam int DEF_STABLE_CYCLES = 256;
  localparam int DEF_MAX_RETRIES   = 7;
  localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic two-flop bit synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;
  logic s1_d, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, waits for and debounces lock, then releases the
// downstream system reset. Runs entirely on the PLL reference clock.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [7:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

  logic lock_s;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (lock),
    .q   (lock_s)
  );

  pll_sup_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lock_lost_q, lock_lost_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;

    unique case (state_q)
      S_PLLRST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Lock takes priority over a timeout landing in the same cycle.
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = S_PLLRST;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          lock_lost_d = 1'b1;
          state_d     = S_PLLRST;
        end
      end
      S_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_PLLRST;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they move with the state flop.
    pll_reset_d = (state_d == S_PLLRST) || (state_d == S_FAIL);
    sys_rst_d   = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= S_PLLRST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized bench for pll_lock_supervisor with a dwell-time
// reference model driven by the same per-cycle reset/lock stimulus.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 16;

  localparam int M_PLLRST = 10;
  localparam int M_WAIT   = 11;
  localparam int M_STABLE = 12;
  localparam int M_RUN    = 13;
  localparam int M_FAIL   = 14;

  logic       clkin;
  logic       reset;
  logic       lock;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [7:0] retry_cnt;

  int vectors;
  int miscompares;

  // Reference model: mode plus the edge count at which it was entered.
  int   m_mode;
  int   m_entry;
  int   m_cyc;
  int   m_retry;
  logic m_lost;
  logic lock_hist[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .CNT_W         (CNT_W)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .lock      (lock),
    .pll_reset (pll_reset),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  function automatic void enter(input int mode);
    m_mode  = mode;
    m_entry = m_cyc;
  endfunction

  function automatic void model_step(input logic r, input logic l);
    logic ls;
    int   dwell;
    m_cyc++;
    if (r) begin
      enter(M_PLLRST);
      m_retry = 0;
      m_lost  = 1'b0;
      lock_hist.delete();
      lock_hist.push_back(1'b0);
      lock_hist.push_back(1'b0);
      return;
    end
    // The lock seen by the FSM is the pin value from two edges earlier.
    ls = lock_hist.pop_front();
    lock_hist.push_back(l);
    dwell = m_cyc - m_entry;
    case (m_mode)
      M_PLLRST: if (dwell == RST_CYCLES) enter(M_WAIT);
      M_WAIT: begin
        if (ls) enter(M_STABLE);
        else if (dwell == LOCK_TIMEOUT) begin
          if (m_retry >= MAX_RETRIES) enter(M_FAIL);
          else begin
            m_retry++;
            enter(M_PLLRST);
          end
        end
      end
      M_STABLE: begin
        if (!ls) enter(M_WAIT);
        else if (dwell == STABLE_CYCLES) begin
          m_retry = 0;
          enter(M_RUN);
        end
      end
      M_RUN: begin
        if (!ls) begin
          m_lost = 1'b1;
          enter(M_PLLRST);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic check_outputs();
    check("pll_reset", {7'd0, pll_reset}, {7'd0, (m_mode == M_PLLRST) || (m_mode == M_FAIL)});
    check("sys_rst",   {7'd0, sys_rst},   {7'd0, m_mode != M_RUN});
    check("ready",     {7'd0, ready},     {7'd0, m_mode == M_RUN});
    check("fail",      {7'd0, fail},      {7'd0, m_mode == M_FAIL});
    check("lock_lost", {7'd0, lock_lost}, {7'd0, m_lost});
    check("retry_cnt", retry_cnt,         8'(m_retry));
  endtask

  task automatic tick(input logic r, input logic l);
    reset = r;
    lock  = l;
    @(posedge clkin);
    model_step(r, l);
    @(negedge clkin);
    check_outputs();
  endtask

  task automatic ticks(input int n, input logic r, input logic l);
    for (int i = 0; i < n; i++) tick(r, l);
  endtask

  initial begin
    int   hold;
    logic lv;
    vectors     = 0;
    miscompares = 0;
    m_cyc       = 0;
    m_mode      = M_PLLRST;
    m_entry     = 0;
    m_retry     = 0;
    m_lost      = 1'b0;
    reset       = 1'b1;
    lock        = 1'b0;

    // Reset values.
    ticks(2, 1'b1, 1'b0);
    check("rst_pll_reset", {7'd0, pll_reset}, 8'd1);
    check("rst_sys_rst",   {7'd0, sys_rst},   8'd1);
    check("rst_retry",     retry_cnt,         8'd0);

    // 1: lock never arrives -> retries exhaust into FAIL.
    ticks(RST_CYCLES - 1, 1'b0, 1'b0);
    check("s1_pll_reset_held", {7'd0, pll_reset}, 8'd1);
    tick(1'b0, 1'b0);
    check("s1_pll_reset_low", {7'd0, pll_reset}, 8'd0);
    ticks(LOCK_TIMEOUT, 1'b0, 1'b0);
    check("s1_retry1", retry_cnt, 8'd1);
    check("s1_repulse", {7'd0, pll_reset}, 8'd1);
    ticks(80, 1'b0, 1'b0);
    check("s1_fail",      {7'd0, fail},      8'd1);
    check("s1_fail_pll",  {7'd0, pll_reset}, 8'd1);
    check("s1_fail_retry", retry_cnt,        8'd2);

    // 5b: reset while in FAIL.
    tick(1'b1, 1'b0);
    check("s5_fail_cleared", {7'd0, fail}, 8'd0);
    tick(1'b1, 1'b0);

    // 2: lock rises 3 cycles into WAIT.
    ticks(RST_CYCLES, 1'b0, 1'b0);
    ticks(3, 1'b0, 1'b0);
    ticks(2 + 1 + STABLE_CYCLES + 2, 1'b0, 1'b1);
    check("s2_ready",   {7'd0, ready},   8'd1);
    check("s2_sys_rst", {7'd0, sys_rst}, 8'd0);

    // 4: lock drop in RUN, then re-lock.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("s4_still_run", {7'd0, ready}, 8'd1);
    tick(1'b0, 1'b1);
    check("s4_lost",     {7'd0, lock_lost}, 8'd1);
    check("s4_sys_rst",  {7'd0, sys_rst},   8'd1);
    ticks(40, 1'b0, 1'b1);
    check("s4_rerun",    {7'd0, ready},     8'd1);
    check("s4_lost_sticky", {7'd0, lock_lost}, 8'd1);

    // 3: single-cycle glitch while in STABLE, plus 5a: reset mid-STABLE.
    tick(1'b1, 1'b0);
    ticks(RST_CYCLES, 1'b0, 1'b0);
    ticks(8, 1'b0, 1'b1);
    tick(1'b0, 1'b0);
    ticks(4, 1'b0, 1'b1);
    check("s3_not_ready", {7'd0, ready}, 8'd0);
    ticks(STABLE_CYCLES + 2, 1'b0, 1'b1);
    check("s3_ready", {7'd0, ready},   8'd1);
    check("s3_retry", retry_cnt,       8'd0);
    tick(1'b1, 1'b1);
    ticks(RST_CYCLES + 5, 1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check("s5_stable_reset", {7'd0, lock_lost}, 8'd0);

    // 6: lock visible exactly when the timeout would fire.
    ticks(RST_CYCLES, 1'b0, 1'b0);
    ticks(LOCK_TIMEOUT - 3, 1'b0, 1'b0);
    ticks(STABLE_CYCLES + 4, 1'b0, 1'b1);
    check("s6_ready", {7'd0, ready}, 8'd1);
    check("s6_retry", retry_cnt,     8'd0);

    // Randomized lock behaviour with occasional resets.
    lv = 1'b0;
    for (int seg = 0; seg < 150; seg++) begin
      lv   = ~lv;
      hold = lv ? $urandom_range(1, 40) : $urandom_range(1, 70);
      for (int k = 0; k < hold; k++) tick(($urandom_range(0, 399) == 0), lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
